// File: rtl/main_pkg.sv
// Shared types and constants for the registered ones counter.
// Optional running total is enabled with the MAIN_ACC_EN macro.
package main_pkg;

   localparam int COUNT_W   = 2;
   localparam int ACC_W_DEF = 8;

   typedef logic [COUNT_W-1:0] count_t;

   function automatic count_t pack_count(input logic c,
                                         input logic s);
      return {c, s};
   endfunction

endpackage

// File: rtl/main_fa_cell.sv
// Purely combinational full adder: counts the ones among x, y, z.
// Used as the leaf cell of main_ones_count.
module main_fa_cell (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/main_ones_count.sv
// Registered 3-input ones counter with valid strobe.
// Define MAIN_ACC_EN to add acc_clear and the ones_total running sum.
module main_ones_count
   import main_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             x,
   input  logic             y,
   input  logic             z,
`ifdef MAIN_ACC_EN
   input  logic             acc_clear,
   output logic [ACC_W-1:0] ones_total,
`endif
   output logic             c,
   output logic             s,
   output logic             out_valid
);

   logic   fa_s;
   logic   fa_c;
   count_t cnt;

   main_fa_cell u_fa (
      .x (x),
      .y (y),
      .z (z),
      .s (fa_s),
      .c (fa_c)
   );

   assign cnt = pack_count(fa_c, fa_s);

   // c/s hold their last value while in_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c         <= 1'b0;
         s         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            {c, s} <= cnt;
         end
      end
   end

`ifdef MAIN_ACC_EN
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W-1:0] acc_next;

   // clear first, then fold in a concurrent sample
   always_comb begin
      acc_base = acc_clear ? '0 : ones_total;
      acc_next = acc_base;
      if (in_valid) begin
         acc_next = acc_base + ACC_W'(cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_total <= '0;
      end else begin
         ones_total <= acc_next;
      end
   end
`endif

endmodule

// File: tb/tb_main_ones_count.sv
// Scoreboard bench for main_ones_count (random + directed stimulus).
// Builds with or without MAIN_ACC_EN.
module tb_main_ones_count;

   localparam int ACC_W = 8;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic x, y, z;
   logic c, s, out_valid;
`ifdef MAIN_ACC_EN
   logic             acc_clear;
   logic [ACC_W-1:0] ones_total;
`endif

   int n_chk;
   int n_fail;

   typedef struct {
      int cnt;
      int total;
   } exp_t;

   exp_t exp_q[$];
   int   last_cnt;
   int   model_total;

   main_ones_count #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .x         (x),
      .y         (y),
      .z         (z),
`ifdef MAIN_ACC_EN
      .acc_clear (acc_clear),
      .ones_total(ones_total),
`endif
      .c         (c),
      .s         (s),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dut_total();
`ifdef MAIN_ACC_EN
      return int'(ones_total);
`else
      return 0;
`endif
   endfunction

   // reference model: the count is just the arithmetic sum of the bits
   always @(posedge clk) begin
      if (rst_n) begin
         int ones;
         int clr;
         ones = int'(x) + int'(y) + int'(z);
         clr = 0;
`ifdef MAIN_ACC_EN
         clr = int'(acc_clear);
`endif
         if (clr != 0) model_total = 0;
         if (in_valid) begin
            model_total = (model_total + ones) % (1 << ACC_W);
            exp_q.push_back('{cnt: ones, total: model_total});
         end
      end
   end

   always @(negedge rst_n) begin
      exp_q.delete();
      last_cnt = 0;
      model_total = 0;
   end

   // monitor: pops one expectation per presented output
   always @(negedge clk) begin
      if (rst_n) begin
         chk("queue_depth_vs_out_valid", exp_q.size(), int'(out_valid));
         if (out_valid && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            last_cnt = e.cnt;
            chk("count", int'({c, s}), e.cnt);
`ifdef MAIN_ACC_EN
            chk("ones_total", dut_total(), e.total);
`endif
         end else begin
            chk("count_hold", int'({c, s}), last_cnt);
`ifdef MAIN_ACC_EN
            chk("ones_total_idle", dut_total(), model_total);
`endif
         end
      end
   end

   task automatic drive(input logic v, input logic [2:0] b, input logic clr);
      @(posedge clk);
      #1;
      in_valid = v;
      {x, y, z} = b;
`ifdef MAIN_ACC_EN
      acc_clear = clr;
`endif
   endtask

   task automatic idle_and_settle();
      drive(1'b0, 3'b000, 1'b0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_cs"}, int'({c, s}), 0);
      chk({name, "_ov"}, int'(out_valid), 0);
`ifdef MAIN_ACC_EN
      chk({name, "_tot"}, dut_total(), 0);
`endif
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      last_cnt = 0;
      model_total = 0;
      rst_n = 1'b0;
      in_valid = 1'b1;
      {x, y, z} = 3'($urandom_range(7));
`ifdef MAIN_ACC_EN
      acc_clear = 1'b0;
`endif
      repeat (3) begin
         @(posedge clk);
         #1;
         {x, y, z} = 3'($urandom_range(7));
         check_reset_outputs("reset_hold");
      end
      in_valid = 1'b0;
      rst_n = 1'b1;

      // exhaustive sweep
      for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0);
      idle_and_settle();
      chk("sweep_last_cs", int'({c, s}), 3);
`ifdef MAIN_ACC_EN
      chk("sweep_total", dut_total(), 12);
`endif

      // valid gating
      drive(1'b1, 3'b111, 1'b0);
      drive(1'b0, 3'b000, 1'b0);
      @(negedge clk);
      chk("gate_cs_first", int'({c, s}), 3);
      chk("gate_ov_first", int'(out_valid), 1);
      @(negedge clk);
      chk("gate_cs_hold", int'({c, s}), 3);
      chk("gate_ov_drop", int'(out_valid), 0);

`ifdef MAIN_ACC_EN
      // wrap and clear
      drive(1'b0, 3'b000, 1'b1);
      for (int i = 0; i < 86; i++) drive(1'b1, 3'b111, 1'b0);
      idle_and_settle();
      chk("wrap_total", dut_total(), 2);
      drive(1'b1, 3'b011, 1'b1);
      idle_and_settle();
      chk("clear_with_sample", dut_total(), 2);
      drive(1'b0, 3'b101, 1'b1);
      idle_and_settle();
      chk("clear_idle", dut_total(), 0);
`endif

      // random traffic
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(1)), 3'($urandom_range(7)),
               1'($urandom_range(15) == 0));
      end

      // asynchronous reset mid-stream, between edges
      drive(1'b1, 3'b111, 1'b0);
      drive(1'b1, 3'b110, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("async_reset_edge");
      rst_n = 1'b1;

      for (int i = 0; i < 100; i++) begin
         drive(1'($urandom_range(1)), 3'($urandom_range(7)),
               1'($urandom_range(15) == 0));
      end
      idle_and_settle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
